// File: rtl/uart_sys_pkg.sv
// Shared types for the UART transmit path: scheduler states and requester IDs.
package uart_sys_pkg;

  localparam int unsigned DATA_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    WAIT_HI,
    WAIT_LO
  } sched_state_e;

  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_RF  = 1'b1
  } src_e;

endpackage

// File: rtl/tx_req_buffer.sv
// One-deep request holding register with pending flag and overflow pulse.
// A strobe arriving in the same cycle the buffer is released is accepted.
module tx_req_buffer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             strobe,
  input  logic [WIDTH-1:0] din,
  input  logic             clr,
  output logic [WIDTH-1:0] data,
  output logic             pending,
  output logic             drop_err
);

  logic has_room;

  assign has_room = !pending || clr;

  // Capture on strobe when there is room, release on clr, flag rejected strobes.
  always_ff @(posedge clk) begin
    if (!rst) begin
      data     <= '0;
      pending  <= 1'b0;
      drop_err <= 1'b0;
    end else begin
      drop_err <= strobe && !has_room;
      if (strobe && has_room) begin
        data    <= din;
        pending <= 1'b1;
      end else if (clr) begin
        pending <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Round-robin sequencer between the ALU (two frames) and register file (one frame)
// in front of the UART transmitter, with handshake retry on busy timeout.
module uart_tx_scheduler #(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned ALU_WIDTH    = 16,
  parameter int unsigned BUSY_TIMEOUT = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  alu_out_valid,
  input  logic [ALU_WIDTH-1:0]  alu_out,
  input  logic                  rd_data_valid,
  input  logic [DATA_WIDTH-1:0] rd_data,
  input  logic                  tx_busy,
  output logic [DATA_WIDTH-1:0] tx_p_data,
  output logic                  tx_data_valid,
  output logic                  alu_pending,
  output logic                  rd_pending,
  output logic                  drop_err,
  output logic                  sched_busy
);

  import uart_sys_pkg::*;

  localparam int unsigned CntW = $clog2(BUSY_TIMEOUT + 1);

  sched_state_e          state;
  src_e                  grant_src;
  src_e                  last_grant;
  src_e                  grant_next;
  logic                  grant_valid;
  logic                  byte_idx;
  logic [CntW-1:0]       tmo_cnt;
  logic [ALU_WIDTH-1:0]  alu_buf;
  logic [DATA_WIDTH-1:0] rd_buf;
  logic                  alu_drop;
  logic                  rd_drop;
  logic                  frame_done;
  logic                  alu_clr;
  logic                  rd_clr;

  tx_req_buffer #(
    .WIDTH (ALU_WIDTH)
  ) u_alu_buf (
    .clk      (clk),
    .rst      (rst),
    .strobe   (alu_out_valid),
    .din      (alu_out),
    .clr      (alu_clr),
    .data     (alu_buf),
    .pending  (alu_pending),
    .drop_err (alu_drop)
  );

  tx_req_buffer #(
    .WIDTH (DATA_WIDTH)
  ) u_rd_buf (
    .clk      (clk),
    .rst      (rst),
    .strobe   (rd_data_valid),
    .din      (rd_data),
    .clr      (rd_clr),
    .data     (rd_buf),
    .pending  (rd_pending),
    .drop_err (rd_drop)
  );

  // Round-robin pick: a lone requester wins, a tie goes to the one not served last.
  always_comb begin
    grant_valid = alu_pending || rd_pending;
    grant_next  = SRC_ALU;
    if (alu_pending && rd_pending) begin
      grant_next = (last_grant == SRC_ALU) ? SRC_RF : SRC_ALU;
    end else if (rd_pending) begin
      grant_next = SRC_RF;
    end
  end

  // Final byte of the granted request has been released by the transmitter.
  assign frame_done = (state == WAIT_LO) && !tx_busy &&
                      !((grant_src == SRC_ALU) && !byte_idx);
  assign alu_clr    = frame_done && (grant_src == SRC_ALU);
  assign rd_clr     = frame_done && (grant_src == SRC_RF);
  assign drop_err   = alu_drop || rd_drop;
  assign sched_busy = (state != IDLE);

  // Byte sequencer; the valid pulse and data byte are registered on entry to SEND.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state         <= IDLE;
      grant_src     <= SRC_ALU;
      last_grant    <= SRC_RF;
      byte_idx      <= 1'b0;
      tmo_cnt       <= '0;
      tx_p_data     <= '0;
      tx_data_valid <= 1'b0;
    end else begin
      tx_data_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (grant_valid) begin
            grant_src     <= grant_next;
            byte_idx      <= 1'b0;
            tx_p_data     <= (grant_next == SRC_ALU) ? alu_buf[DATA_WIDTH-1:0] : rd_buf;
            tx_data_valid <= 1'b1;
            state         <= SEND;
          end
        end
        SEND: begin
          tmo_cnt <= '0;
          state   <= WAIT_HI;
        end
        WAIT_HI: begin
          if (tx_busy) begin
            state <= WAIT_LO;
          end else if (tmo_cnt == CntW'(BUSY_TIMEOUT - 1)) begin
            // Transmitter never acknowledged: re-pulse the same byte.
            tx_data_valid <= 1'b1;
            state         <= SEND;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        WAIT_LO: begin
          if (!tx_busy) begin
            if ((grant_src == SRC_ALU) && !byte_idx) begin
              byte_idx      <= 1'b1;
              tx_p_data     <= alu_buf[ALU_WIDTH-1:DATA_WIDTH];
              tx_data_valid <= 1'b1;
              state         <= SEND;
            end else begin
              last_grant <= grant_src;
              state      <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Bench for uart_tx_scheduler: a transaction-level reference thread predicts every
// output each cycle; directed scenarios add hand-computed expectations on top.
module tb_uart_tx_scheduler;

  localparam int TMO = 15;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        alu_out_valid = 1'b0;
  logic [15:0] alu_out = '0;
  logic        rd_data_valid = 1'b0;
  logic [7:0]  rd_data = '0;
  logic        tx_busy = 1'b0;
  logic [7:0]  tx_p_data;
  logic        tx_data_valid;
  logic        alu_pending;
  logic        rd_pending;
  logic        drop_err;
  logic        sched_busy;

  always #5 clk = ~clk;

  uart_tx_scheduler #(
    .DATA_WIDTH   (8),
    .ALU_WIDTH    (16),
    .BUSY_TIMEOUT (TMO)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .alu_out_valid (alu_out_valid),
    .alu_out       (alu_out),
    .rd_data_valid (rd_data_valid),
    .rd_data       (rd_data),
    .tx_busy       (tx_busy),
    .tx_p_data     (tx_p_data),
    .tx_data_valid (tx_data_valid),
    .alu_pending   (alu_pending),
    .rd_pending    (rd_pending),
    .drop_err      (drop_err),
    .sched_busy    (sched_busy)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int n_drop   = 0;
  bit cmp_on   = 1'b0;

  typedef struct {
    int         c;
    logic [7:0] d;
  } pulse_t;
  pulse_t pulses[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Transmitter model: busy rises tx_lat+1 cycles after a valid pulse for tx_len cycles.
  bit tx_ignore_next = 1'b0;
  bit tx_rand        = 1'b0;
  int tx_lat = 1, tx_len = 11, tx_wait = 0, tx_rem = 0;

  always @(posedge clk) begin : tx_model
    bit v, r;
    v = tx_data_valid;
    r = rst;
    #1;
    if (!r) begin
      tx_busy = 1'b0;
      tx_wait = 0;
      tx_rem  = 0;
    end else if (v === 1'b1) begin
      if (tx_ignore_next || (tx_rand && $urandom_range(7) == 0)) begin
        tx_ignore_next = 1'b0;
      end else begin
        if (tx_rand) begin
          tx_lat = $urandom_range(4, 1);
          tx_len = $urandom_range(11, 1);
        end
        tx_wait = tx_lat;
      end
    end else if (tx_wait > 0) begin
      tx_wait--;
      if (tx_wait == 0) begin
        tx_busy = 1'b1;
        tx_rem  = tx_len;
      end
    end else if (tx_busy) begin
      tx_rem--;
      if (tx_rem == 0) tx_busy = 1'b0;
    end
  end

  // Reference model state: buffers plus expected outputs for the current cycle.
  bit         m_alu_pend = 0, m_rd_pend = 0, m_drop = 0, m_last_rf = 1;
  logic [15:0] m_alu = '0;
  logic [7:0]  m_rd = '0;
  bit         e_valid = 0, e_sbusy = 0;
  logic [7:0]  e_data = '0;
  bit         s_busy = 0, rst_seen = 0, last_wait = 0, cur_alu = 0;

  // Advance one clock: apply reset, requester strobes, and release of a finished request.
  task automatic tick();
    bit sa, sr, rel, rel_a, rel_r;
    logic [15:0] da;
    logic [7:0]  dr;
    @(posedge clk);
    sa = alu_out_valid; sr = rd_data_valid; da = alu_out; dr = rd_data; s_busy = tx_busy;
    if (!rst) begin
      m_alu_pend = 0; m_rd_pend = 0; m_drop = 0; m_last_rf = 1; m_alu = '0; m_rd = '0;
      e_valid = 0; e_sbusy = 0; e_data = '0; last_wait = 0; rst_seen = 1;
      return;
    end
    rel   = last_wait && !s_busy;
    rel_a = rel && cur_alu;
    rel_r = rel && !cur_alu;
    if (rel) m_last_rf = !cur_alu;
    m_drop = 0;
    if (sa) begin
      if (!m_alu_pend || rel_a) begin m_alu = da; m_alu_pend = 1; end
      else m_drop = 1;
    end else if (rel_a) m_alu_pend = 0;
    if (sr) begin
      if (!m_rd_pend || rel_r) begin m_rd = dr; m_rd_pend = 1; end
      else m_drop = 1;
    end else if (rel_r) m_rd_pend = 0;
  endtask

  // Serve one request from an idle cycle: each byte is offered until acknowledged,
  // then held until the transmitter releases it.
  task automatic serve_one();
    int nbytes;
    bit acked;
    logic [7:0] b;
    e_sbusy = 0; e_valid = 0; last_wait = 0;
    if (!m_alu_pend && !m_rd_pend) begin
      tick();
      return;
    end
    cur_alu = m_alu_pend && (!m_rd_pend || m_last_rf);
    nbytes  = cur_alu ? 2 : 1;
    tick();
    if (rst_seen) return;
    for (int i = 0; i < nbytes; i++) begin
      b = !cur_alu ? m_rd : ((i == 0) ? m_alu[7:0] : m_alu[15:8]);
      acked = 0;
      while (!acked) begin
        e_sbusy = 1; e_valid = 1; e_data = b;
        tick();
        if (rst_seen) return;
        e_valid = 0;
        for (int w = 0; w < TMO && !acked; w++) begin
          tick();
          if (rst_seen) return;
          if (s_busy) acked = 1;
        end
      end
      last_wait = (i == nbytes - 1);
      do begin
        tick();
        if (rst_seen) return;
      end while (s_busy);
      last_wait = 0;
    end
  endtask

  initial begin : model_thread
    forever begin
      rst_seen = 0;
      serve_one();
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (cmp_on) begin
      if (tx_data_valid === 1'b1) pulses.push_back('{c: cyc, d: tx_p_data});
      if (drop_err === 1'b1) n_drop++;
      check("cycle_outputs",
            {19'd0, tx_data_valid, tx_p_data, alu_pending, rd_pending, drop_err, sched_busy},
            {19'd0, e_valid, e_data, m_alu_pend, m_rd_pend, m_drop, e_sbusy});
    end
  end

  task automatic strobe(input bit a, input logic [15:0] av, input bit r, input logic [7:0] rv);
    alu_out_valid = a; alu_out = av; rd_data_valid = r; rd_data = rv;
    @(negedge clk);
    alu_out_valid = 0; rd_data_valid = 0;
  endtask

  task automatic wait_quiet();
    int n, q;
    n = 0; q = 0;
    while (q < 3 && n < 2000) begin
      @(negedge clk);
      n++;
      if (!sched_busy && !alu_pending && !rd_pending && !tx_busy) q++;
      else q = 0;
    end
    if (q < 3) begin
      n_checks++;
      n_fail++;
      $display("FAIL wait_quiet: still busy after %0d cycles", n);
    end
  endtask

  task automatic check_order(input string name, input logic [7:0] b0, input logic [7:0] b1,
                             input logic [7:0] b2);
    check({name, "_count"}, pulses.size(), 3);
    if (pulses.size() == 3) begin
      check({name, "_b0"}, pulses[0].d, b0);
      check({name, "_b1"}, pulses[1].d, b1);
      check({name, "_b2"}, pulses[2].d, b2);
    end
  endtask

  initial begin : watchdog
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int k, n;
    rst = 0;
    repeat (3) @(negedge clk);
    rst = 1;
    cmp_on = 1;
    check("reset_tx_p_data", tx_p_data, 8'h00);
    check("reset_tx_data_valid", tx_data_valid, 1'b0);
    check("reset_pending", {alu_pending, rd_pending}, 2'b00);
    check("reset_sched_busy", sched_busy, 1'b0);

    // Tie straight out of reset: ALU wins, its two bytes precede the RF byte.
    pulses.delete();
    strobe(1, 16'hBEEF, 1, 8'h5C);
    wait_quiet();
    check_order("contention_a", 8'hEF, 8'hBE, 8'h5C);

    // RF alone: valid pulse two cycles after the strobe cycle.
    pulses.delete();
    k = cyc;
    strobe(0, 16'h0, 1, 8'hA5);
    wait_quiet();
    check("rf_count", pulses.size(), 1);
    if (pulses.size() > 0) begin
      check("rf_data", pulses[0].d, 8'hA5);
      check("rf_latency", pulses[0].c - k, 2);
    end

    // ALU alone: busy spans 11 cycles from two after the pulse, so the high byte
    // follows the low one 14 cycles later.
    pulses.delete();
    strobe(1, 16'h1234, 0, 8'h0);
    wait_quiet();
    check("alu_count", pulses.size(), 2);
    if (pulses.size() == 2) begin
      check("alu_lo", pulses[0].d, 8'h34);
      check("alu_hi", pulses[1].d, 8'h12);
      check("alu_gap", pulses[1].c - pulses[0].c, 14);
    end

    // ALU was served last, so RF wins this tie.
    pulses.delete();
    strobe(1, 16'hBEEF, 1, 8'h5C);
    wait_quiet();
    check_order("contention_b", 8'h5C, 8'hEF, 8'hBE);

    // Overflow: a second RF strobe while one is buffered is dropped.
    pulses.delete();
    n_drop = 0;
    strobe(0, 16'h0, 1, 8'h11);
    strobe(0, 16'h0, 1, 8'h77);
    wait_quiet();
    check("ovf_drop_count", n_drop, 1);
    check("ovf_count", pulses.size(), 1);
    if (pulses.size() > 0) check("ovf_data", pulses[0].d, 8'h11);

    // Timeout: first pulse ignored, same byte re-offered 1 + 15 cycles later.
    pulses.delete();
    tx_ignore_next = 1;
    strobe(0, 16'h0, 1, 8'h5A);
    wait_quiet();
    check("tmo_count", pulses.size(), 2);
    if (pulses.size() == 2) begin
      check("tmo_b0", pulses[0].d, 8'h5A);
      check("tmo_b1", pulses[1].d, 8'h5A);
      check("tmo_gap", pulses[1].c - pulses[0].c, 16);
    end

    // Reset while the ALU low byte is held by the transmitter.
    pulses.delete();
    strobe(1, 16'h1234, 0, 8'h0);
    n = 0;
    while (tx_busy !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("rst_busy_seen", tx_busy, 1'b1);
    @(negedge clk);
    rst = 0;
    @(negedge clk);
    rst = 1;
    check("rst_outputs",
          {tx_p_data, tx_data_valid, alu_pending, rd_pending, drop_err, sched_busy}, 13'd0);
    repeat (30) @(negedge clk);
    check("rst_no_hi_byte", pulses.size(), 1);
    pulses.delete();
    strobe(0, 16'h0, 1, 8'h3C);
    wait_quiet();
    check("rst_after_count", pulses.size(), 1);
    if (pulses.size() > 0) check("rst_after_data", pulses[0].d, 8'h3C);

    // Random traffic against the model, with random transmitter timing and misses.
    tx_rand = 1;
    for (int i = 0; i < 3000; i++) begin
      alu_out_valid = ($urandom_range(5) == 0);
      alu_out       = 16'($urandom);
      rd_data_valid = ($urandom_range(5) == 0);
      rd_data       = 8'($urandom);
      @(negedge clk);
    end
    alu_out_valid = 0;
    rd_data_valid = 0;
    wait_quiet();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
